// File: rtl/accumulator_64_if.sv
// accumulator_64_if: burst handshake, external adder hookup and result signals of accumulator_64
interface accumulator_64_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  modport master (
    output start, burst_len, din, din_valid, add_sum,
    input  din_ready, add_a, add_b, acc, ovf, count, busy, done
  );
  modport slave (
    input  start, burst_len, din, din_valid, add_sum,
    output din_ready, add_a, add_b, acc, ovf, count, busy, done
  );
endinterface

// File: rtl/accumulator_64.sv
// accumulator_64: burst accumulator around an external combinational adder (ACC->A, OPB->B, SUM->ACC)
module accumulator_64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  accumulator_64_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, opb_q, opb_d;
  logic [CNT_W-1:0] count_q, count_d, len_q, len_d;
  logic             ovf_q, ovf_d, opbv_q, opbv_d;
  logic             start_ok, accept, last;
  always_comb begin
    start_ok = state_q == IDLE && bus.start;
    accept   = state_q == RUN && bus.din_valid;
    last     = accept && count_q + CNT_W'(1) == len_q;
    state_d  = state_q == IDLE  ? (bus.start ? (bus.burst_len == '0 ? DONE : RUN) : IDLE) :
               state_q == RUN   ? (last ? DRAIN : RUN) :
               state_q == DRAIN ? DONE : IDLE;
    acc_d    = start_ok ? '0 : opbv_q ? bus.add_sum[WIDTH-1:0] : acc_q;
    ovf_d    = start_ok ? 1'b0 : ovf_q | (opbv_q & bus.add_sum[WIDTH]);
    opb_d    = start_ok ? '0 : accept ? bus.din : opb_q;
    opbv_d   = accept;
    count_d  = start_ok ? '0 : accept ? count_q + CNT_W'(1) : count_q;
    len_d    = start_ok ? bus.burst_len : len_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      opbv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      opbv_q  <= opbv_d;
    end
  end
  assign bus.add_a     = acc_q;
  assign bus.add_b     = opb_q;
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;
  assign bus.din_ready = state_q == RUN;
  assign bus.busy      = state_q == RUN || state_q == DRAIN;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_accumulator_64.sv
// tb_accumulator_64: randomized and directed bursts checked every cycle against a queue-based sum model
module tb_accumulator_64;
  localparam int W = 64;
  localparam int C = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  accumulator_64_if #(.WIDTH(W), .CNT_W(C)) bus();
  accumulator_64 #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  always #5 clk = ~clk;
  int             phase = 0;
  logic [C-1:0]   m_len = '0;
  logic [W-1:0]   ops[$];
  bit             pend = 1'b0;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = 0;
      ops.delete();
      pend = 1'b0;
      m_len = '0;
    end else begin
      pend = phase == 1 && bus.din_valid;
      case (phase)
        0: if (bus.start) begin
          ops.delete();
          m_len = bus.burst_len;
          phase = m_len == '0 ? 3 : 1;
        end
        1: if (bus.din_valid) begin
          ops.push_back(bus.din);
          if (ops.size() == int'(m_len)) phase = 2;
        end
        2: phase = 3;
        default: phase = 0;
      endcase
    end
  end
  initial begin
    logic [W-1:0] a;
    logic [W:0]   t;
    bit           o;
    int           n;
    forever begin
      @(negedge clk);
      a = '0;
      o = 1'b0;
      n = ops.size() - (pend ? 1 : 0);
      for (int i = 0; i < n; i++) begin
        t = {1'b0, a} + {1'b0, ops[i]};
        a = t[W-1:0];
        o = o | t[W];
      end
      chk("acc", bus.acc, a);
      chk("add_a", bus.add_a, a);
      chk("ovf", W'(bus.ovf), W'(o));
      chk("add_b", bus.add_b, ops.size() > 0 ? ops[$] : '0);
      chk("count", W'(bus.count), W'(ops.size()));
      chk("din_ready", W'(bus.din_ready), W'(phase == 1));
      chk("busy", W'(bus.busy), W'(phase == 1 || phase == 2));
      chk("done", W'(bus.done), W'(phase == 3));
      if (bus.done) dones++;
    end
  end
  task automatic begin_burst(input logic [C-1:0] len);
    @(negedge clk);
    bus.start = 1'b1;
    bus.burst_len = len;
    bus.din_valid = 1'($urandom);
    bus.din = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b0;
    bus.din_valid = 1'b0;
  endtask
  task automatic send(input logic [W-1:0] v, input int gaps);
    for (int i = 0; i < gaps; i++) begin
      bus.din_valid = 1'b0;
      bus.din = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.din_valid = 1'b1;
    bus.din = v;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask
  task automatic wait_done(input logic [W-1:0] ea, input bit eo, input int ew, input string n);
    int w = 0;
    while (bus.done !== 1'b1 && w < 50) begin
      bus.din_valid = 1'($urandom);
      bus.din = {$urandom, $urandom};
      @(negedge clk);
      w++;
    end
    bus.din_valid = 1'b0;
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", n, w);
    end else begin
      chk({n, "_acc"}, bus.acc, ea);
      chk({n, "_ovf"}, W'(bus.ovf), W'(eo));
      if (ew >= 0) chk({n, "_latency"}, W'(w), W'(ew));
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] s, v;
    logic [W:0]   t;
    bit           o;
    int           len, d;
    bus.start = 1'b0;
    bus.burst_len = '0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_acc", bus.acc, '0);
    chk("rst_count", W'(bus.count), '0);
    chk("rst_ready", W'(bus.din_ready), '0);
    chk("rst_done", W'(bus.done), '0);
    rst = 1'b0;
    begin_burst(3);
    send(W'(1), 0);
    chk("sum3_cnt1", W'(bus.count), W'(1));
    send(W'(2), 0);
    chk("sum3_cnt2", W'(bus.count), W'(2));
    send(W'(3), 0);
    chk("sum3_cnt3", W'(bus.count), W'(3));
    wait_done(W'(6), 1'b0, 1, "sum3");
    begin_burst(2);
    send({W{1'b1}}, 0);
    send(W'(1), 0);
    wait_done('0, 1'b1, 1, "ovf");
    begin_burst(1);
    send(W'(5), 0);
    wait_done(W'(5), 1'b0, 1, "ovf_clear");
    begin_burst(4);
    send(W'(10), 0);
    send(W'(20), 1);
    send(W'(30), 2);
    send(W'(40), 0);
    wait_done(W'(100), 1'b0, 1, "gap");
    begin_burst(0);
    wait_done('0, 1'b0, 0, "zero");
    begin_burst(1);
    send(W'(7), 0);
    wait_done(W'(7), 1'b0, 1, "pre_done_start");
    bus.start = 1'b1;
    bus.burst_len = C'(9);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_busy", W'(bus.busy), '0);
    chk("done_start_acc", bus.acc, W'(7));
    begin_burst(3);
    send(W'(4), 0);
    bus.start = 1'b1;
    bus.burst_len = C'(9);
    send(W'(5), 0);
    bus.start = 1'b0;
    chk("run_start_cnt", W'(bus.count), W'(2));
    send(W'(6), 0);
    wait_done(W'(15), 1'b0, 1, "run_start");
    begin_burst(5);
    send(W'(11), 0);
    send(W'(12), 0);
    d = dones;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_acc", bus.acc, '0);
    chk("mid_rst_count", W'(bus.count), '0);
    chk("mid_rst_busy", W'(bus.busy), '0);
    chk("mid_rst_ready", W'(bus.din_ready), '0);
    chk("mid_rst_add_b", bus.add_b, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_rst_no_done", W'(dones), W'(d));
    begin_burst(2);
    send(W'(1), 0);
    send(W'(2), 0);
    wait_done(W'(3), 1'b0, 1, "after_rst");
    for (int a = 0; a <= 32; a++)
      for (int b = 0; b <= 32; b++) begin
        begin_burst(2);
        send(W'(a), 0);
        send(W'(b), 0);
        wait_done(W'(a + b), 1'b0, 1, "sweep");
      end
    repeat (200) begin
      len = $urandom_range(1, 8);
      s = '0;
      o = 1'b0;
      begin_burst(C'(len));
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 100)) : {$urandom, $urandom};
        t = {1'b0, s} + {1'b0, v};
        s = t[W-1:0];
        o = o | t[W];
        send(v, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      wait_done(s, o, 1, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
